// File: rtl/uart_pkg.sv
// Shared UART definitions: frame width and receiver/transmitter state encodings.
// Used by uart_rx and uart_tx.
package uart_pkg;

    localparam int UART_FRAME_DATA_BITS = 8;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_START_BIT  = 3'd1;
    localparam logic [2:0] ST_DATA_BITS  = 3'd2;
    localparam logic [2:0] ST_PARITY_BIT = 3'd3;
    localparam logic [2:0] ST_STOP_BIT   = 3'd4;
    localparam logic [2:0] ST_CLEANUP    = 3'd5;

    typedef enum logic [2:0] {
        IDLE       = ST_IDLE,
        START_BIT  = ST_START_BIT,
        DATA_BITS  = ST_DATA_BITS,
        PARITY_BIT = ST_PARITY_BIT,
        STOP_BIT   = ST_STOP_BIT,
        CLEANUP    = ST_CLEANUP
    } uart_state_e;

    function automatic logic even_parity(input logic [UART_FRAME_DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// RESET_VALUE sets the level both flops take during reset.
module uart_rx_sync #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clock,
    input  logic reset_n,
    input  logic line_async,
    output logic line_sync
);

    logic meta;

    // Two back-to-back flops to settle metastability on the raw line
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            meta      <= RESET_VALUE;
            line_sync <= RESET_VALUE;
        end else begin
            meta      <= line_async;
            line_sync <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1, LSB first, mid-bit sampling.
// Define UART_RX_PARITY_EN for 8E1 frames with a parity_error output.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLOCKS_PER_BIT = 434
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       serial_in,
    output logic [7:0] received_data,
    output logic       data_valid,
    output logic       is_receiving,
    output logic       framing_error
`ifdef UART_RX_PARITY_EN
    ,
    output logic       parity_error
`endif
);

    localparam int CW = $clog2(CLOCKS_PER_BIT);
    localparam int IW = $clog2(UART_FRAME_DATA_BITS);
    localparam logic [CW-1:0] LAST_CNT = CW'(CLOCKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_CNT = CW'((CLOCKS_PER_BIT - 1) / 2);
    localparam logic [IW-1:0] LAST_IDX = IW'(UART_FRAME_DATA_BITS - 1);

    logic                            line;
    uart_state_e                     state;
    logic [CW-1:0]                   counter;
    logic [IW-1:0]                   bit_index;
    logic [UART_FRAME_DATA_BITS-1:0] shift_reg;
`ifdef UART_RX_PARITY_EN
    logic                            parity_bit;
`endif

    uart_rx_sync #(
        .RESET_VALUE (1'b1)
    ) u_sync (
        .clock      (clock),
        .reset_n    (reset_n),
        .line_async (serial_in),
        .line_sync  (line)
    );

    // Frame FSM: detect start, sample each bit at its centre, check stop
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            counter       <= '0;
            bit_index     <= '0;
            shift_reg     <= '0;
            received_data <= '0;
            data_valid    <= 1'b0;
            framing_error <= 1'b0;
            is_receiving  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bit    <= 1'b0;
            parity_error  <= 1'b0;
`endif
        end else begin
            data_valid    <= 1'b0;
            framing_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_error  <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    counter   <= '0;
                    bit_index <= '0;
                    if (!line) begin
                        state        <= START_BIT;
                        is_receiving <= 1'b1;
                    end
                end
                START_BIT: begin
                    if (counter == HALF_CNT) begin
                        counter <= '0;
                        if (!line) begin
                            state <= DATA_BITS;
                        end else begin
                            state        <= IDLE;
                            is_receiving <= 1'b0;
                        end
                    end else begin
                        counter <= counter + CW'(1);
                    end
                end
                DATA_BITS: begin
                    if (counter == LAST_CNT) begin
                        counter              <= '0;
                        shift_reg[bit_index] <= line;
                        if (bit_index == LAST_IDX) begin
                            bit_index <= '0;
`ifdef UART_RX_PARITY_EN
                            state     <= PARITY_BIT;
`else
                            state     <= STOP_BIT;
`endif
                        end else begin
                            bit_index <= bit_index + IW'(1);
                        end
                    end else begin
                        counter <= counter + CW'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY_BIT: begin
                    if (counter == LAST_CNT) begin
                        counter    <= '0;
                        parity_bit <= line;
                        state      <= STOP_BIT;
                    end else begin
                        counter <= counter + CW'(1);
                    end
                end
`endif
                STOP_BIT: begin
                    if (counter == LAST_CNT) begin
                        counter <= '0;
                        state   <= CLEANUP;
                        if (!line) begin
                            framing_error <= 1'b1;
                        end
`ifdef UART_RX_PARITY_EN
                        else if (parity_bit != even_parity(shift_reg)) begin
                            parity_error <= 1'b1;
                        end
`endif
                        else begin
                            received_data <= shift_reg;
                            data_valid    <= 1'b1;
                        end
                    end else begin
                        counter <= counter + CW'(1);
                    end
                end
                CLEANUP: begin
                    counter      <= '0;
                    is_receiving <= 1'b0;
                    state        <= IDLE;
                end
                default: begin
                    counter      <= '0;
                    bit_index    <= '0;
                    is_receiving <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx at 16 clocks per bit.
// Expected values are hand-computed per frame.
module tb_uart_rx;

    localparam int CPB = 16;

    logic       clock;
    logic       reset_n;
    logic       serial_in;
    logic [7:0] received_data;
    logic       data_valid;
    logic       is_receiving;
    logic       framing_error;
`ifdef UART_RX_PARITY_EN
    logic       parity_error;
`endif

    int n_checks;
    int n_pass;

    int         valid_cnt;
    int         ferr_cnt;
    int         perr_cnt;
    int         both_cnt;
    int         rx_cycles;
    logic [7:0] data_log[$];

    uart_rx #(
        .CLOCKS_PER_BIT (CPB)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .serial_in     (serial_in),
        .received_data (received_data),
        .data_valid    (data_valid),
        .is_receiving  (is_receiving),
        .framing_error (framing_error)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_error  (parity_error)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Count output events on the falling edge, away from updates
    always @(negedge clock) begin
        if (data_valid) begin
            valid_cnt++;
            data_log.push_back(received_data);
        end
        if (framing_error) ferr_cnt++;
        if (data_valid && framing_error) both_cnt++;
`ifdef UART_RX_PARITY_EN
        if (parity_error) perr_cnt++;
        if (parity_error && (data_valid || framing_error)) both_cnt++;
`endif
        if (is_receiving) rx_cycles++;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_counts();
        valid_cnt = 0;
        ferr_cnt  = 0;
        perr_cnt  = 0;
        rx_cycles = 0;
        data_log.delete();
    endtask

    task automatic drive_bit(input logic b);
        serial_in = b;
        repeat (CPB) @(negedge clock);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop,
                              input logic par_flip);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit((^d) ^ par_flip);
`endif
        drive_bit(stop);
        serial_in = 1'b1;
    endtask

    task automatic idle(input int n);
        serial_in = 1'b1;
        repeat (n) @(negedge clock);
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        both_cnt  = 0;
        reset_n   = 1'b0;
        serial_in = 1'b1;
        clear_counts();
        repeat (3) @(negedge clock);
        check("rst_data", {24'd0, received_data}, 32'h00);
        check("rst_valid", {31'd0, data_valid}, 32'd0);
        check("rst_ferr", {31'd0, framing_error}, 32'd0);
        check("rst_busy", {31'd0, is_receiving}, 32'd0);
        reset_n = 1'b1;
        idle(5);

        // Single frame 0x55
        clear_counts();
        send_frame(8'h55, 1'b1, 1'b0);
        idle(10);
        check("f55_cnt", valid_cnt, 1);
        check("f55_log", (data_log.size() > 0) ? {24'd0, data_log[0]} : 32'hdead, 32'h55);
        check("f55_data", {24'd0, received_data}, 32'h55);
        check("f55_ferr", ferr_cnt, 0);
        check("f55_busylen", rx_cycles, 153);
        check("f55_idle", {31'd0, is_receiving}, 32'd0);

        // Back-to-back frames, stop bit exactly one bit time
        clear_counts();
        send_frame(8'hA5, 1'b1, 1'b0);
        send_frame(8'h3C, 1'b1, 1'b0);
        idle(10);
        check("b2b_cnt", valid_cnt, 2);
        check("b2b_first", (data_log.size() > 0) ? {24'd0, data_log[0]} : 32'hdead, 32'hA5);
        check("b2b_second", (data_log.size() > 1) ? {24'd0, data_log[1]} : 32'hdead, 32'h3C);
        check("b2b_ferr", ferr_cnt, 0);

        // Short low glitch on idle line
        clear_counts();
        serial_in = 1'b0;
        repeat (3) @(negedge clock);
        idle(40);
        check("gl_valid", valid_cnt, 0);
        check("gl_ferr", ferr_cnt, 0);
        check("gl_busylen", rx_cycles, 8);
        check("gl_idle", {31'd0, is_receiving}, 32'd0);

        // 0xFF with low stop bit
        clear_counts();
        send_frame(8'hFF, 1'b0, 1'b0);
        idle(40);
        check("fe_cnt", ferr_cnt, 1);
        check("fe_valid", valid_cnt, 0);
        check("fe_hold", {24'd0, received_data}, 32'h3C);
        check("fe_idle", {31'd0, is_receiving}, 32'd0);

        // Reset after bit 3 of 0x81, then 0x42
        clear_counts();
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b0);
        reset_n   = 1'b0;
        serial_in = 1'b1;
        repeat (3) @(negedge clock);
        check("mr_data", {24'd0, received_data}, 32'h00);
        check("mr_busy", {31'd0, is_receiving}, 32'd0);
        reset_n = 1'b1;
        idle(CPB * 6);
        check("mr_nopulse", valid_cnt + ferr_cnt, 0);
        send_frame(8'h42, 1'b1, 1'b0);
        idle(10);
        check("mr_cnt", valid_cnt, 1);
        check("mr_data42", {24'd0, received_data}, 32'h42);
        check("mr_ferr", ferr_cnt, 0);

`ifdef UART_RX_PARITY_EN
        // 0x07 has odd weight, even parity bit must be 1
        clear_counts();
        send_frame(8'h07, 1'b1, 1'b1);
        idle(10);
        check("par_bad_perr", perr_cnt, 1);
        check("par_bad_valid", valid_cnt, 0);
        clear_counts();
        send_frame(8'h07, 1'b1, 1'b0);
        idle(10);
        check("par_ok_valid", valid_cnt, 1);
        check("par_ok_data", {24'd0, received_data}, 32'h07);
        check("par_ok_perr", perr_cnt, 0);
`endif

        check("never_both", both_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
- REQ-001 The block SHALL have parameter CLOCKS_PER_BIT, default 434, meaning clock cycles per UART bit (clock frequency / baud rate), legal range 4..511.
- REQ-002 The block SHALL have port clock  input  1  the single system clock; all state is updated on its rising edge.
- REQ-003 The block SHALL have port reset_n  input  1  asynchronous, active-low reset.
- REQ-004 The block SHALL have port serial_in  input  1  asynchronous UART line, idle high.
- REQ-005 The block SHALL have port received_data  output  8  last correctly framed byte.
- REQ-006 The block SHALL have port data_valid  output  1  one-cycle pulse qualifying received_data.
- REQ-007 The block SHALL have port is_receiving  output  1  high from start-bit detection until the frame ends.
- REQ-008 The block SHALL have port framing_error  output  1  one-cycle pulse when the stop bit samples low.

Function
- REQ-009 serial_in SHALL pass through a two-flop synchronizer (reset value 1) before any use; "line" below means the synchronized value.
- REQ-010 The state machine SHALL have states IDLE, START_BIT, DATA_BITS, STOP_BIT and CLEANUP; any unused encoding SHALL go to IDLE.
- REQ-011 IDLE: counter and bit index SHALL be held at 0; line low SHALL move the block to START_BIT and set is_receiving.
- REQ-012 START_BIT: after (CLOCKS_PER_BIT-1)/2 further cycles (mid-bit), line low SHALL move the block to DATA_BITS with counter cleared.
- REQ-013 START_BIT: if the line is high at mid-bit, the block SHALL treat it as a glitch, return to IDLE, clear is_receiving and raise no pulse.
- REQ-014 DATA_BITS: every CLOCKS_PER_BIT cycles the line SHALL be sampled into shift bit current_index, LSB first, 8 samples in all; then the block SHALL enter STOP_BIT.
- REQ-015 STOP_BIT: after CLOCKS_PER_BIT cycles, line high SHALL load received_data and pulse data_valid for exactly one cycle.
- REQ-016 STOP_BIT: after CLOCKS_PER_BIT cycles, line low SHALL pulse framing_error for one cycle and leave received_data unchanged.
- REQ-017 After STOP_BIT the block SHALL enter CLEANUP for one cycle, clear is_receiving and return to IDLE.
- REQ-018 A new start bit SHALL be accepted from the first IDLE cycle; there is no inter-frame gap requirement beyond the stop bit.
- REQ-019 received_data SHALL hold its value between frames; data_valid and framing_error SHALL never be high together.
- REQ-020 The counter SHALL be $clog2(CLOCKS_PER_BIT) bits wide, SHALL compare against CLOCKS_PER_BIT-1 and SHALL clear on every bit boundary.

Reset
- REQ-021 reset_n low SHALL immediately force state IDLE, counter 0, index 0, received_data 8'h00, and data_valid, framing_error and is_receiving 0, with synchronizer flops at 1.
- REQ-022 Reset asserted mid-frame SHALL abandon the frame with no pulse; after release the block SHALL resynchronize on the next falling edge.

Configuration
- REQ-023 With UART_RX_PARITY_EN defined, a PARITY_BIT state SHALL follow DATA_BITS and sample one even-parity bit.
- REQ-024 With UART_RX_PARITY_EN defined, output parity_error SHALL pulse one cycle in place of data_valid on mismatch; framing_error SHALL take priority.
- REQ-025 Without UART_RX_PARITY_EN, the frame SHALL be 8N1 and the parity_error port SHALL be absent.

Structure
- REQ-026 The state encoding localparams and the UART_FRAME_DATA_BITS=8 constant SHALL live in shared package uart_pkg, also used by UART_TX.
- REQ-027 The synchronizer SHALL be sub-module uart_rx_sync (2-flop, parameterized reset value); everything else SHALL stay in uart_rx.

Verification (CLOCKS_PER_BIT=16 unless stated)
- REQ-028 Drive 8N1 frame 0x55 -> one data_valid pulse, received_data=0x55, is_receiving high for about 10x16 cycles.
- REQ-029 Drive 0xA5 then 0x3C back-to-back with stop bits of exactly 16 cycles -> two data_valid pulses carrying 0xA5 then 0x3C.
- REQ-030 Drive a 3-cycle low glitch on an idle line -> return to IDLE, no data_valid, no framing_error.
- REQ-031 Drive 0xFF with the stop bit held low -> framing_error pulses once, data_valid stays 0, received_data keeps its previous value.
- REQ-032 Assert reset_n after bit 3 of 0x81, then send 0x42 -> no pulse for 0x81, data_valid with 0x42.
- REQ-033 With UART_RX_PARITY_EN, send 0x07 with parity bit 0 -> parity_error pulses once; with parity bit 1 -> data_valid pulses with 0x07.
